vram_access_arbiter: RTL and testbench

- Shares the 16 KB sub-system VRAM between two requesters: the display fetch path (character-boundary loads from the video timing generator) and the sub CPU (via a REQ/ACK handshake).
- Display fetch has absolute priority.
- CPU accesses fill the free slots, either anywhere or only during blanking, selected by a parameter.
- Sits between the timing generator, the sub-CPU bus interface and the VRAM array.

---
 rtl/vram_access_arbiter_pkg.sv | 14 +
 rtl/vram_access_arbiter_if.sv | 54 +++++
 rtl/vram_access_arbiter_lat_counter.sv | 40 ++++
 rtl/vram_access_arbiter.sv | 150 +++++++++++++++
 tb/tb_vram_access_arbiter.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_access_arbiter_pkg.sv
// Shared video sub-system definitions: arbiter state encoding and VRAM geometry.
package video_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DSP  = 2'd1,
    CPU  = 2'd2
  } arb_state_e;

  localparam int unsigned VRAM_AW     = 14;
  localparam int unsigned VRAM_DW     = 8;
  localparam int unsigned DEF_MEM_LAT = 2;

endpackage

// File: rtl/vram_access_arbiter_if.sv
// Bundle of timing-generator, sub-CPU and VRAM-array signals seen by the arbiter.
interface vram_access_arbiter_if
  import video_pkg::*;
#(
  parameter int unsigned ADDR_W = VRAM_AW,
  parameter int unsigned DATA_W = VRAM_DW
) ();

  // timing generator
  logic              HBLANKn;
  logic              VBLANKn;
  logic              DISP_REQ;
  logic [ADDR_W-1:0] DISP_ADDR;
  logic [ADDR_W-1:0] VOFFSET;
  logic [DATA_W-1:0] DISP_DATA;
  logic              DISP_VALID;
  logic              DISP_OVR;

  // sub-CPU bus
  logic              CPU_REQ;
  logic              CPU_WE;
  logic [ADDR_W-1:0] CPU_ADDR;
  logic [DATA_W-1:0] CPU_WDATA;
  logic              CPU_ACK;
  logic [DATA_W-1:0] CPU_RDATA;
  logic              CPU_WAIT;

  // VRAM array
  logic [ADDR_W-1:0] VRAM_ADDR;
  logic              VRAM_WE;
  logic [DATA_W-1:0] VRAM_WDATA;
  logic [DATA_W-1:0] VRAM_RDATA;

  // arbiter side
  modport slave (
    input  HBLANKn, VBLANKn, DISP_REQ, DISP_ADDR, VOFFSET,
    input  CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA,
    input  VRAM_RDATA,
    output DISP_DATA, DISP_VALID, DISP_OVR,
    output CPU_ACK, CPU_RDATA, CPU_WAIT,
    output VRAM_ADDR, VRAM_WE, VRAM_WDATA
  );

  // requester / memory side
  modport master (
    output HBLANKn, VBLANKn, DISP_REQ, DISP_ADDR, VOFFSET,
    output CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA,
    output VRAM_RDATA,
    input  DISP_DATA, DISP_VALID, DISP_OVR,
    input  CPU_ACK, CPU_RDATA, CPU_WAIT,
    input  VRAM_ADDR, VRAM_WE, VRAM_WDATA
  );

endinterface

// File: rtl/vram_access_arbiter_lat_counter.sv
// Memory-latency counter: cleared on load, counts while enabled,
// flags the last cycle (MEM_LAT-1) of an access.
module lat_counter #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_LAT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // next count: load wins over increment
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/vram_access_arbiter.sv
// VRAM arbiter: display fetches have absolute priority, sub-CPU accesses
// fill free slots (optionally only during blanking). No preemption.
module vram_access_arbiter
  import video_pkg::*;
#(
  parameter int unsigned ADDR_W     = VRAM_AW,
  parameter int unsigned DATA_W     = VRAM_DW,
  parameter int unsigned MEM_LAT    = DEF_MEM_LAT,
  parameter bit          BLANK_ONLY = 1'b1
) (
  input  logic                 CLKSYS,
  input  logic                 SRESETn,
  vram_access_arbiter_if.slave bus
);

  arb_state_e        state_q, state_d;
  logic              disp_pend_q, disp_pend_d;
  logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;
  logic              ovr_q, ovr_d;
  logic [ADDR_W-1:0] vaddr_q, vaddr_d;
  logic              vwe_q, vwe_d;
  logic [DATA_W-1:0] vwdata_q, vwdata_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] ddata_q, ddata_d;
  logic              dvalid_q, dvalid_d;
  logic              cnt_load;
  logic              cnt_en;
  logic              cnt_tc;
  logic              cpu_ok;

  assign cpu_ok = BLANK_ONLY ? ~(bus.HBLANKn & bus.VBLANKn) : 1'b1;

  lat_counter #(
    .MEM_LAT (MEM_LAT)
  ) u_lat (
    .clk    (CLKSYS),
    .rst_n  (SRESETn),
    .load_i (cnt_load),
    .en_i   (cnt_en),
    .tc_o   (cnt_tc)
  );

  // next state, request bookkeeping and datapath loads
  always_comb begin
    state_d     = state_q;
    disp_pend_d = disp_pend_q;
    disp_addr_d = disp_addr_q;
    ovr_d       = ovr_q;
    vaddr_d     = vaddr_q;
    vwe_d       = vwe_q;
    vwdata_d    = vwdata_q;
    ack_d       = 1'b0;
    rdata_d     = rdata_q;
    ddata_d     = ddata_q;
    dvalid_d    = 1'b0;
    cnt_load    = 1'b0;
    cnt_en      = 1'b0;

    // latest request always replaces the pending address; a request
    // arriving while one is still outstanding is an overrun
    if (bus.DISP_REQ) begin
      disp_pend_d = 1'b1;
      disp_addr_d = bus.DISP_ADDR;
      if (disp_pend_q || (state_q == DSP)) begin
        ovr_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (disp_pend_q || bus.DISP_REQ) begin
          state_d     = DSP;
          vaddr_d     = bus.DISP_REQ ? bus.DISP_ADDR : disp_addr_q;
          disp_pend_d = 1'b0;
          cnt_load    = 1'b1;
        end else if (bus.CPU_REQ && cpu_ok && !ack_q) begin
          state_d  = CPU;
          vaddr_d  = bus.CPU_ADDR + bus.VOFFSET;
          vwe_d    = bus.CPU_WE;
          vwdata_d = bus.CPU_WDATA;
          cnt_load = 1'b1;
        end
      end
      DSP: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          ddata_d  = bus.VRAM_RDATA;
          dvalid_d = 1'b1;
          state_d  = IDLE;
        end
      end
      CPU: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          if (!vwe_q) begin
            rdata_d = bus.VRAM_RDATA;
          end
          ack_d   = 1'b1;
          vwe_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and output registers; reset aborts any access in flight
  always_ff @(posedge CLKSYS or negedge SRESETn) begin
    if (!SRESETn) begin
      state_q     <= IDLE;
      disp_pend_q <= 1'b0;
      disp_addr_q <= '0;
      ovr_q       <= 1'b0;
      vaddr_q     <= '0;
      vwe_q       <= 1'b0;
      vwdata_q    <= '0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      ddata_q     <= '0;
      dvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      disp_pend_q <= disp_pend_d;
      disp_addr_q <= disp_addr_d;
      ovr_q       <= ovr_d;
      vaddr_q     <= vaddr_d;
      vwe_q       <= vwe_d;
      vwdata_q    <= vwdata_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      ddata_q     <= ddata_d;
      dvalid_q    <= dvalid_d;
    end
  end

  assign bus.VRAM_ADDR  = vaddr_q;
  assign bus.VRAM_WE    = vwe_q;
  assign bus.VRAM_WDATA = vwdata_q;
  assign bus.CPU_ACK    = ack_q;
  assign bus.CPU_RDATA  = rdata_q;
  assign bus.DISP_DATA  = ddata_q;
  assign bus.DISP_VALID = dvalid_q;
  assign bus.DISP_OVR   = ovr_q;
  // held low during reset so every output reads 0 while SRESETn is asserted
  assign bus.CPU_WAIT   = SRESETn & bus.CPU_REQ & ~ack_q & (state_q != CPU);

endmodule

// File: tb/tb_vram_access_arbiter.sv
// Directed bench for vram_access_arbiter: a blank-only instance (main DUT)
// plus an interleaving instance sharing the same stimulus.
module tb_vram_access_arbiter;
  import video_pkg::*;

  localparam int unsigned MEM_LAT = 2;

  logic clk;
  logic rst_n;

  int unsigned n_cmp;
  int unsigned n_err;

  logic [13:0] wr_addr;
  logic [7:0]  wr_data;

  vram_access_arbiter_if #(.ADDR_W(14), .DATA_W(8)) b1 ();
  vram_access_arbiter_if #(.ADDR_W(14), .DATA_W(8)) b0 ();

  vram_access_arbiter #(
    .ADDR_W     (14),
    .DATA_W     (8),
    .MEM_LAT    (MEM_LAT),
    .BLANK_ONLY (1'b1)
  ) u_dut (
    .CLKSYS  (clk),
    .SRESETn (rst_n),
    .bus     (b1.slave)
  );

  vram_access_arbiter #(
    .ADDR_W     (14),
    .DATA_W     (8),
    .MEM_LAT    (MEM_LAT),
    .BLANK_ONLY (1'b0)
  ) u_dut_il (
    .CLKSYS  (clk),
    .SRESETn (rst_n),
    .bus     (b0.slave)
  );

  // VRAM content pattern; written locations are tracked separately
  function automatic logic [7:0] pat(input logic [13:0] a);
    if (a == 14'h0100) return 8'h5A;
    return a[7:0] ^ {2'b00, a[13:8]} ^ 8'hC3;
  endfunction

  assign b1.VRAM_RDATA = pat(b1.VRAM_ADDR);
  assign b0.VRAM_RDATA = pat(b0.VRAM_ADDR);

  assign b0.HBLANKn   = b1.HBLANKn;
  assign b0.VBLANKn   = b1.VBLANKn;
  assign b0.DISP_REQ  = b1.DISP_REQ;
  assign b0.DISP_ADDR = b1.DISP_ADDR;
  assign b0.VOFFSET   = b1.VOFFSET;
  assign b0.CPU_REQ   = b1.CPU_REQ;
  assign b0.CPU_WE    = b1.CPU_WE;
  assign b0.CPU_ADDR  = b1.CPU_ADDR;
  assign b0.CPU_WDATA = b1.CPU_WDATA;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (b1.VRAM_WE) begin
      wr_addr <= b1.VRAM_ADDR;
      wr_data <= b1.VRAM_WDATA;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return {21'd0, b1.VRAM_ADDR, b1.VRAM_WE, b1.VRAM_WDATA, b1.CPU_ACK, b1.CPU_RDATA,
            b1.CPU_WAIT, b1.DISP_DATA, b1.DISP_VALID, b1.DISP_OVR};
  endfunction

  initial begin
    int unsigned ack_at;
    int unsigned ack_cnt;
    int unsigned we_cnt;
    int unsigned v_cnt;
    int unsigned seen60;
    int unsigned ack1;
    int unsigned ack2;
    int unsigned grant_at;
    logic        wait_ok;
    logic        disp_first;
    logic [7:0]  d_data;
    logic [7:0]  r_data;
    logic        ign_wait;

    n_cmp = 0;
    n_err = 0;
    clk   = 1'b0;
    rst_n = 1'b0;
    b1.HBLANKn   = 1'b1;
    b1.VBLANKn   = 1'b1;
    b1.DISP_REQ  = 1'b0;
    b1.DISP_ADDR = '0;
    b1.VOFFSET   = '0;
    b1.CPU_REQ   = 1'b0;
    b1.CPU_WE    = 1'b0;
    b1.CPU_ADDR  = '0;
    b1.CPU_WDATA = '0;

    // reset state
    tick(); tick(); tick();
    check("reset_outs", all_outs(), 64'd0);
    rst_n = 1'b1;
    tick();
    check("idle_outs", all_outs(), 64'd0);

    // blank-only gating of a CPU read
    b1.CPU_REQ  = 1'b1;
    b1.CPU_WE   = 1'b0;
    b1.CPU_ADDR = 14'h0100;
    tick();
    check("active_wait", {63'd0, b1.CPU_WAIT}, 64'd1);
    check("active_noaddr", {50'd0, b1.VRAM_ADDR}, 64'd0);
    check("il_grant_addr", {50'd0, b0.VRAM_ADDR}, 64'h0100);
    check("il_grant_nowait", {63'd0, b0.CPU_WAIT}, 64'd0);
    b1.HBLANKn = 1'b0;
    ack_at = 0;
    r_data = '0;
    for (int unsigned i = 1; i <= 8; i++) begin
      tick();
      if (i == 1) begin
        check("blank_grant_addr", {50'd0, b1.VRAM_ADDR}, 64'h0100);
        check("blank_grant_nowait", {63'd0, b1.CPU_WAIT}, 64'd0);
      end
      if (b1.CPU_ACK && ack_at == 0) begin
        ack_at = i;
        r_data = b1.CPU_RDATA;
        b1.CPU_REQ = 1'b0;
      end
    end
    check("rd_ack_latency", 64'(ack_at), 64'(MEM_LAT + 1));
    check("rd_data", {56'd0, r_data}, 64'h5A);
    check("rd_data_held", {56'd0, b1.CPU_RDATA}, 64'h5A);

    // write with offset wrap at 16K
    b1.CPU_REQ   = 1'b1;
    b1.CPU_WE    = 1'b1;
    b1.CPU_ADDR  = 14'h3FF0;
    b1.VOFFSET   = 14'h0020;
    b1.CPU_WDATA = 8'hA5;
    we_cnt  = 0;
    ack_cnt = 0;
    for (int unsigned i = 1; i <= 8; i++) begin
      tick();
      if (i == 1) begin
        check("wr_wrap_addr", {50'd0, b1.VRAM_ADDR}, 64'h0010);
        check("wr_wdata", {56'd0, b1.VRAM_WDATA}, 64'hA5);
      end
      if (b1.VRAM_WE) we_cnt++;
      if (b1.CPU_ACK) begin
        ack_cnt++;
        b1.CPU_REQ = 1'b0;
        b1.CPU_WE  = 1'b0;
      end
    end
    check("wr_we_cycles", 64'(we_cnt), 64'(MEM_LAT));
    check("wr_ack_count", 64'(ack_cnt), 64'd1);
    check("wr_mem", {42'd0, wr_addr, wr_data}, {42'd0, 14'h0010, 8'hA5});
    b1.VOFFSET = '0;

    // simultaneous display and CPU request: display first
    b1.DISP_REQ  = 1'b1;
    b1.DISP_ADDR = 14'h0050;
    b1.CPU_REQ   = 1'b1;
    b1.CPU_ADDR  = 14'h0200;
    tick();
    b1.DISP_REQ = 1'b0;
    check("tie_dsp_addr", {50'd0, b1.VRAM_ADDR}, 64'h0050);
    wait_ok    = 1'b1;
    disp_first = 1'b0;
    d_data     = '0;
    grant_at   = 0;
    ack_at     = 0;
    for (int unsigned i = 1; i <= 12; i++) begin
      if (grant_at == 0 && !b1.CPU_WAIT && !b1.CPU_ACK) begin
        grant_at = i;
        check("tie_cpu_addr", {50'd0, b1.VRAM_ADDR}, 64'h0200);
      end
      if (grant_at == 0 && !b1.CPU_WAIT) wait_ok = 1'b0;
      if (b1.DISP_VALID) begin
        disp_first = (grant_at == 0);
        d_data     = b1.DISP_DATA;
      end
      if (b1.CPU_ACK && ack_at == 0) begin
        ack_at = i;
        r_data = b1.CPU_RDATA;
        b1.CPU_REQ = 1'b0;
      end
      tick();
    end
    check("tie_wait_held", {63'd0, wait_ok}, 64'd1);
    check("tie_disp_first", {63'd0, disp_first}, 64'd1);
    check("tie_disp_data", {56'd0, d_data}, 64'h93);
    check("tie_grant_cycle", 64'(grant_at), 64'd4);
    check("tie_cpu_rdata", {56'd0, r_data}, 64'hC1);

    // back-to-back display requests during a CPU access -> overrun
    b1.CPU_REQ  = 1'b1;
    b1.CPU_ADDR = 14'h0300;
    tick();
    b1.DISP_REQ  = 1'b1;
    b1.DISP_ADDR = 14'h0060;
    tick();
    b1.DISP_ADDR = 14'h0070;
    tick();
    b1.DISP_REQ = 1'b0;
    check("ovr_ack", {63'd0, b1.CPU_ACK}, 64'd1);
    b1.CPU_REQ = 1'b0;
    check("ovr_set", {63'd0, b1.DISP_OVR}, 64'd1);
    v_cnt  = 0;
    seen60 = 0;
    d_data = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      tick();
      if (b1.DISP_VALID) begin
        v_cnt++;
        d_data = b1.DISP_DATA;
      end
      if (b1.VRAM_ADDR == 14'h0060) seen60++;
    end
    check("ovr_valid_count", 64'(v_cnt), 64'd1);
    check("ovr_disp_data", {56'd0, d_data}, 64'hB3);
    check("ovr_first_dropped", 64'(seen60), 64'd0);
    check("ovr_sticky", {63'd0, b1.DISP_OVR}, 64'd1);

    // REQ held through ACK: turnaround cycle then a second access
    b1.CPU_REQ  = 1'b1;
    b1.CPU_ADDR = 14'h0400;
    ack1 = 0;
    ack2 = 0;
    ign_wait = 1'b0;
    for (int unsigned i = 1; i <= 20; i++) begin
      tick();
      if (ack1 != 0 && i == ack1 + 1) ign_wait = b1.CPU_WAIT;
      if (b1.CPU_ACK) begin
        if (ack1 == 0) begin
          ack1 = i;
        end else if (ack2 == 0) begin
          ack2 = i;
          b1.CPU_REQ = 1'b0;
        end
      end
    end
    check("b2b_ack1", 64'(ack1), 64'(MEM_LAT + 1));
    check("b2b_gap", 64'(ack2 - ack1), 64'(MEM_LAT + 2));
    check("b2b_turnaround_wait", {63'd0, ign_wait}, 64'd1);
    check("b2b_rdata", {56'd0, b1.CPU_RDATA}, 64'hC7);

    // reset in the middle of a CPU write
    b1.CPU_REQ   = 1'b1;
    b1.CPU_WE    = 1'b1;
    b1.CPU_ADDR  = 14'h0500;
    b1.CPU_WDATA = 8'h11;
    tick();
    check("rst_we_before", {63'd0, b1.VRAM_WE}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_outs", all_outs(), 64'd0);
    ack_cnt = 0;
    tick();
    if (b1.CPU_ACK) ack_cnt++;
    b1.CPU_REQ = 1'b0;
    b1.CPU_WE  = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      tick();
      if (b1.CPU_ACK) ack_cnt++;
    end
    check("rst_no_ack", 64'(ack_cnt), 64'd0);
    check("rst_idle_outs", all_outs(), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
